// File: rtl/lsu_pkg.sv
// Shared types and lane helpers for the load/store unit: access sizes, FSM state
// encodings, load-lane extraction and store-lane merge for a 32-bit word memory.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_ILL  = 2'b11
    } size_e;

    typedef logic [2:0] lsu_state_e;

    localparam lsu_state_e ST_IDLE   = 3'd0;
    localparam lsu_state_e ST_RD     = 3'd1;
    localparam lsu_state_e ST_RMW_RD = 3'd2;
    localparam lsu_state_e ST_WR     = 3'd3;
    localparam lsu_state_e ST_RESP   = 3'd4;

    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  off,
                                                 input size_e       size,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{off, 3'b000} +: 8];
        h = off[1] ? word[31:16] : word[15:0];
        case (size)
            SZ_BYTE: r = {{24{~uns & b[7]}}, b};
            SZ_HALF: r = {{16{~uns & h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  off,
                                                input size_e       size);
        logic [31:0] r;
        r = word;
        case (size)
            SZ_BYTE: r[{off, 3'b000} +: 8] = wdata[7:0];
            SZ_HALF: begin
                if (off[1]) r[31:16] = wdata[15:0];
                else        r[15:0]  = wdata[15:0];
            end
            default: r = wdata;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge into a
// read word, and alignment checking of an incoming request. Zero latency, no flow control.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    input  logic [1:0]  off,
    input  size_e       size,
    input  logic        uns,
    input  logic [1:0]  chk_off,
    input  size_e       chk_size,
    output logic [31:0] ext_dat,
    output logic [31:0] merge_dat,
    output logic        misalign
);

    always_comb begin
        ext_dat   = lane_extract(rd_word, off, size, uns);
        merge_dat = store_merge(rd_word, wdata, off, size);
        case (chk_size)
            SZ_BYTE: misalign = 1'b0;
            SZ_HALF: misalign = chk_off[0];
            SZ_WORD: misalign = |chk_off;
            default: misalign = 1'b1;
        endcase
    end

endmodule

// File: rtl/lsu.sv
// Load/store unit FSM: one request at a time, sub-word stores done as read-modify-write.
// Zero-wait latency: error 1, load/word store 2, sub-word store 3 cycles; mem_ready=0 stretches.
module lsu
    import lsu_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    lsu_state_e        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    size_e             size_q, size_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic [31:0] ext_dat;
    logic [31:0] merge_dat;
    logic        misalign;

    lsu_align u_align (
        .rd_word   (mem_rdata),
        .wdata     (wdata_q),
        .off       (addr_q[1:0]),
        .size      (size_q),
        .uns       (uns_q),
        .chk_off   (req_addr[1:0]),
        .chk_size  (size_e'(req_size)),
        .ext_dat   (ext_dat),
        .merge_dat (merge_dat),
        .misalign  (misalign)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        size_d  = size_q;
        uns_d   = uns_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    size_d  = size_e'(req_size);
                    uns_d   = req_unsigned;
                    wdata_d = req_wdata;
                    if (misalign) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = ST_RESP;
                    end else if (!req_we) begin
                        state_d = ST_RD;
                    end else if (size_e'(req_size) == SZ_WORD) begin
                        state_d = ST_WR;
                    end else begin
                        state_d = ST_RMW_RD;
                    end
                end
            end
            ST_RD: begin
                if (mem_ready) begin
                    rdata_d = ext_dat;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RMW_RD: begin
                // wdata_q is reused to hold the merged word for the write phase
                if (mem_ready) begin
                    wdata_d = merge_dat;
                    state_d = ST_WR;
                end
            end
            ST_WR: begin
                if (mem_ready) begin
                    rdata_d = '0;
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            uns_q   <= 1'b0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            uns_q   <= uns_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign mem_read  = (state_q == ST_RD) || (state_q == ST_RMW_RD);
    assign mem_write = (state_q == ST_WR);
    assign rsp_valid = (state_q == ST_RESP);
    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;
    assign mem_addr  = {2'b00, addr_q[ADDR_W-1:2]};
    assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: vector table of requests against a small word memory model,
// plus hand sequences for held requests during busy and reset during read-modify-write.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_read, mem_write, mem_ready;

    logic [31:0] mem [16];
    assign mem_rdata = mem[mem_addr[3:0]];

    always #5 clk = ~clk;

    lsu #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
        .rsp_rdata(rsp_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          stall;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
    } vec_t;

    vec_t        vecs[$];
    int          n_cmp = 0, n_bad = 0;
    int          stall = 0, nrsp = 0, rd_cyc = 0, wr_cyc = 0, bad_flag = 0;
    logic [31:0] last_rdata = '0, exp_maddr = '0;
    logic        last_err = 1'b0;

    function automatic vec_t mk(logic we, logic [1:0] size, logic uns, logic [31:0] addr,
                                logic [31:0] wdata, int stl, logic [31:0] erd, logic eerr,
                                int elat, int erdc, int ewrc);
        vec_t v;
        v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
        v.stall = stl; v.exp_rdata = erd; v.exp_err = eerr; v.exp_lat = elat;
        v.exp_rd = erdc; v.exp_wr = ewrc;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Advance to the next falling edge, record DUT activity, and act as the memory.
    task automatic tick();
        @(negedge clk);
        if (rsp_valid) begin
            nrsp++;
            last_rdata = rsp_rdata;
            last_err   = rsp_err;
        end
        if (mem_read)  rd_cyc++;
        if (mem_write) wr_cyc++;
        if (mem_read && mem_write) bad_flag++;
        if ((mem_read || mem_write) && mem_addr !== exp_maddr) bad_flag++;
        if ((mem_read || mem_write) && stall > 0) begin
            mem_ready = 1'b0;
            stall--;
        end else begin
            mem_ready = 1'b1;
            if (mem_write) mem[mem_addr[3:0]] = mem_wdata;
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata, output int lat);
        int n;
        int r0;
        req_we = we; req_size = size; req_unsigned = uns;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        r0 = nrsp;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (nrsp == r0 && lat < 50) begin tick(); lat++; end
    endtask

    initial begin
        int lat, rd0, wr0, bad0, r0, n;
        vec_t v;

        //            we   sz    u   addr      wdata       stl  rdata        err lat rd wr
        vecs.push_back(mk(1, 2'd2, 0, 32'h10, 32'hDEADBEEF, 0, 32'h0,        0, 2, 0, 1));
        vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0,        0, 32'hDEADBEEF, 0, 2, 1, 0));
        vecs.push_back(mk(1, 2'd2, 0, 32'h10, 32'h11223344, 0, 32'h0,        0, 2, 0, 1));
        vecs.push_back(mk(1, 2'd0, 0, 32'h12, 32'h123456AA, 0, 32'h0,        0, 3, 1, 1));
        vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0,        0, 32'h11AA3344, 0, 2, 1, 0));
        vecs.push_back(mk(1, 2'd2, 0, 32'h10, 32'h80FF7F01, 0, 32'h0,        0, 2, 0, 1));
        vecs.push_back(mk(0, 2'd0, 0, 32'h12, 32'h0,        0, 32'hFFFFFFFF, 0, 2, 1, 0));
        vecs.push_back(mk(0, 2'd0, 1, 32'h12, 32'h0,        0, 32'h000000FF, 0, 2, 1, 0));
        vecs.push_back(mk(0, 2'd1, 0, 32'h12, 32'h0,        0, 32'hFFFF80FF, 0, 2, 1, 0));
        vecs.push_back(mk(0, 2'd0, 0, 32'h10, 32'h0,        0, 32'h00000001, 0, 2, 1, 0));
        vecs.push_back(mk(0, 2'd0, 0, 32'h13, 32'h0,        0, 32'hFFFFFF80, 0, 2, 1, 0));
        vecs.push_back(mk(0, 2'd0, 1, 32'h13, 32'h0,        0, 32'h00000080, 0, 2, 1, 0));
        vecs.push_back(mk(0, 2'd1, 1, 32'h10, 32'h0,        0, 32'h00007F01, 0, 2, 1, 0));
        vecs.push_back(mk(1, 2'd1, 0, 32'h12, 32'hFFFFBEEF, 0, 32'h0,        0, 3, 1, 1));
        vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0,        0, 32'hBEEF7F01, 0, 2, 1, 0));
        vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0,        3, 32'hBEEF7F01, 0, 5, 4, 0));
        vecs.push_back(mk(1, 2'd0, 0, 32'h11, 32'h00000055, 2, 32'h0,        0, 5, 3, 1));
        vecs.push_back(mk(0, 2'd2, 0, 32'h10, 32'h0,        0, 32'hBEEF5501, 0, 2, 1, 0));
        vecs.push_back(mk(0, 2'd1, 0, 32'h11, 32'h0,        0, 32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(1, 2'd2, 0, 32'h12, 32'h12345678, 0, 32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(0, 2'd3, 0, 32'h10, 32'h0,        0, 32'h0,        1, 1, 0, 0));
        vecs.push_back(mk(1, 2'd1, 0, 32'h13, 32'h0000CAFE, 0, 32'h0,        1, 1, 0, 0));

        for (int i = 0; i < 16; i++) mem[i] = '0;
        req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = '0; req_wdata = '0; mem_ready = 1'b1;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_err",   {31'b0, rsp_err},   32'd0);
        check("rst_rsp_rdata", rsp_rdata,          32'd0);
        check("rst_strobes",   {30'b0, mem_read, mem_write}, 32'd0);
        check("rst_mem_addr",  mem_addr,           32'd0);
        check("rst_mem_wdata", mem_wdata,          32'd0);
        rst_n = 1'b1;
        tick();
        check("post_rst_req_ready", {31'b0, req_ready}, 32'd1);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            stall = v.stall;
            exp_maddr = {2'b00, v.addr[31:2]};
            rd0 = rd_cyc; wr0 = wr_cyc; bad0 = bad_flag;
            issue(v.we, v.size, v.uns, v.addr, v.wdata, lat);
            check($sformatf("v%0d_lat", i),   lat, v.exp_lat);
            check($sformatf("v%0d_rdata", i), last_rdata, v.exp_rdata);
            check($sformatf("v%0d_err", i),   {31'b0, last_err}, {31'b0, v.exp_err});
            check($sformatf("v%0d_rd_cyc", i), rd_cyc - rd0, v.exp_rd);
            check($sformatf("v%0d_wr_cyc", i), wr_cyc - wr0, v.exp_wr);
            check($sformatf("v%0d_strobe_addr", i), bad_flag - bad0, 32'd0);
        end
        check("mem_word4_after_table", mem[4], 32'hBEEF5501);

        // Second request held while the first is in flight
        exp_maddr = 32'h4;
        req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0; req_addr = 32'h10;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 10) begin tick(); n++; end
        r0 = nrsp;
        tick();
        req_size = 2'd0; req_unsigned = 1'b1; req_addr = 32'h13;
        n = 1;
        while (!req_ready && n < 20) begin tick(); n++; end
        check("bp_accept_gap", n, 32'd3);
        check("bp_first_rsp_cnt", nrsp - r0, 32'd1);
        check("bp_first_rdata", last_rdata, 32'hBEEF5501);
        r0 = nrsp;
        tick();
        req_valid = 1'b0;
        lat = 1;
        while (nrsp == r0 && lat < 20) begin tick(); lat++; end
        check("bp_second_lat", lat, 32'd2);
        check("bp_second_rdata", last_rdata, 32'h000000BE);
        repeat (3) tick();
        check("rdata_hold", rsp_rdata, 32'h000000BE);
        check("idle_no_rsp", {31'b0, rsp_valid}, 32'd0);

        // Reset while a byte store is in its read phase
        stall = 10;
        req_we = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h10; req_wdata = 32'h00000077; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        check("rmw_read_active", {31'b0, mem_read}, 32'd1);
        r0 = nrsp; wr0 = wr_cyc;
        #2 rst_n = 1'b0;
        #1;
        check("rstmid_mem_read", {31'b0, mem_read}, 32'd0);
        check("rstmid_mem_write", {31'b0, mem_write}, 32'd0);
        check("rstmid_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        @(negedge clk);
        stall = 0;
        rst_n = 1'b1;
        repeat (4) tick();
        check("rstmid_no_rsp", nrsp - r0, 32'd0);
        check("rstmid_no_write", wr_cyc - wr0, 32'd0);
        check("rstmid_mem_word", mem[4], 32'hBEEF5501);
        check("rstmid_req_ready", {31'b0, req_ready}, 32'd1);

        issue(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, lat);
        check("post_rst_load_lat", lat, 32'd2);
        check("post_rst_load_rdata", last_rdata, 32'h0000BEEF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lsu.md
# lsu

Load/store unit between the execute stage and the `mmu` memory block. It accepts one byte, halfword or word load/store request at a time and checks alignment. It turns sub-word stores into a read-modify-write, because `mmu` only writes whole words. It extracts and sign- or zero-extends load data and returns a single-cycle response.

## Interface
Parameters:
- `ADDR_W`, 32: byte-address width of requests.
- `DATA_W`, 32: data width; fixed at 32 for this design.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `req_valid` in 1: request present; held stable until accepted.
- `req_ready` out 1: high only in IDLE; acceptance is `req_valid && req_ready`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: one-cycle response pulse.
- `rsp_err` out 1: qualified by `rsp_valid`; misaligned or illegal size.
- `rsp_rdata` out 32: load result; 0 for stores and errors.
- `mem_addr` out 32: word index `{2'b00, addr[31:2]}`, driven into `mmu.virtual_addr`.
- `mem_wdata` out 32: full word to write.
- `mem_read` out 1: read strobe.
- `mem_write` out 1: write strobe.
- `mem_rdata` in 32: from `mmu.data_out`.
- `mem_ready` in 1: from `mmu.mem_ready`; may be combinational, same cycle as the strobe.

## Operation
- State machine states: IDLE, RD, RMW_RD, WR, RESP.
  - Next-state logic is registered.
  - `mem_read`, `mem_write` and `req_ready` are decoded from the state only (Moore).
- IDLE, on acceptance:
  - Latch addr, size, we, unsigned and wdata.
  - Misaligned or illegal size → RESP with err=1; no memory access.
  - Load → RD.
  - Word store → WR with `mem_wdata = wdata`.
  - Byte/half store → RMW_RD.
- Misaligned means:
  - half with addr[0]=1;
  - word with addr[1:0]≠00;
  - size=11 (illegal).
- RD:
  - `mem_read=1`; wait while `mem_ready=0`.
  - On `mem_ready`: register the extracted lane → RESP.
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Extend to 32 bits per `req_unsigned`.
- RMW_RD:
  - `mem_read=1`; on `mem_ready`, merge the new byte/half into the read word at its lane → WR.
- WR:
  - `mem_write=1`, `mem_wdata` = registered merged word.
  - On `mem_ready` → RESP.
- RESP: `rsp_valid=1` for exactly one cycle → IDLE. There is no response backpressure.
- `mem_addr` is constant for the whole transaction.
- Only one strobe is ever high at a time; never both.

## Timing
- Reset values: state IDLE; `req_ready=1`; all other outputs 0 (`rsp_valid`, `rsp_err`, `rsp_rdata`, `mem_*`).
- Latency with a zero-wait `mmu`, request accepted at edge of cycle N; `rsp_valid` high in:
  - load or word store: cycle N+2;
  - byte/half store: cycle N+3;
  - error: cycle N+1.
- Each cycle with `mem_ready=0` adds one cycle.
- Peak throughput: one request per 3 cycles. `req_ready` returns high in the cycle after RESP.
- `req_valid` while not in IDLE: ignored; the requester must hold it.
- `rsp_rdata` and `rsp_err` are valid only while `rsp_valid=1`. They hold their value until the next response.
- Reset asserted mid-transaction:
  - all strobes drop asynchronously, state → IDLE;
  - no response is issued, and a partially completed RMW does not write.
- `mem_ready` high in a state with no strobe has no effect.

## Structure
- `lsu_pkg` holds:
  - `size_e` (BYTE/HALF/WORD/ILL);
  - `lsu_state_e`;
  - the lane-extract function and the store-merge function.
- Sub-module `lsu_align` is purely combinational and contains:
  - extraction and extension, (word, addr[1:0], size, unsigned) → data;
  - merge, (word, wdata, addr[1:0], size) → word;
  - misalignment detection.
- `lsu` keeps only the state machine and its registers.

## Test plan
- Word store then load: store 0xDEADBEEF at addr 0x10 → one write cycle with `mem_addr=4`. Load word at 0x10 → `rsp_rdata=0xDEADBEEF`, rsp_valid at N+2.
- Byte store RMW: word 4 = 0x11223344; store byte 0xAA at 0x12 → read then write of 0x11AA3344, response at N+3.
- Byte loads, sign vs zero: word = 0x80FF7F01.
  - Signed byte at 0x12 → 0xFFFFFFFF.
  - Unsigned byte at 0x12 → 0x000000FF.
  - Signed half at 0x12 → 0xFFFF80FF.
  - Signed byte at 0x10 → 0x00000001.
- Misaligned: half load at 0x11, word store at 0x12, size=11 → `rsp_err=1` at N+1 with no `mem_read`/`mem_write` pulse.
- Wait states and backpressure:
  - Hold `mem_ready=0` for 3 cycles → strobe held, response delayed by 3.
  - `req_valid` held during the busy period is accepted only after RESP.
- Reset in RMW_RD: assert `rst_n=0` while `mem_read=1` → strobes 0 immediately, memory word unchanged, no `rsp_valid`, `req_ready=1` after release.
